// File: rtl/ula_bus_arbiter.sv
// Three-way round-robin bus arbiter driving tri-state buffer enables; registered grant, 1-cycle req-to-gnt from IDLE.
// Requesters hold req until served; MAX_HOLD caps tenure when others wait. Optional bus parking via ULA_BUS_PARK_EN.
module ula_bus_arbiter #(
  parameter int MAX_HOLD    = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [2:0] en,
  output logic [1:0] owner,
  output logic       parked
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_gnt, w_gnt_nxt;
  logic [2:0] r_en, w_en_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] r_last, w_last_nxt;
  logic [1:0] r_turn_cnt, w_turn_nxt;
  logic [3:0] r_hold_cnt, w_hold_nxt;
  logic       w_pick_vld;
  logic [1:0] w_pick_idx;
  logic       w_do_grant;
  logic       w_others;

`ifdef ULA_BUS_PARK_EN
  logic       r_parked, w_parked_nxt;
  logic       r_park_vld, w_park_vld_nxt;
`endif

  function automatic logic [1:0] f_inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] f_onehot(input logic [1:0] x);
    case (x)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [1:0] f_enc(input logic [2:0] g);
    case (g)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Round-robin pick: first set request walking ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    logic [1:0] cand;
    w_pick_vld = 1'b0;
    w_pick_idx = 2'd0;
    cand       = r_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!w_pick_vld && req[cand]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = cand;
      end
      cand = f_inc3(cand);
    end
  end

  assign w_others = |(req & ~r_gnt);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_hold_nxt  = r_hold_cnt;
    w_turn_nxt  = r_turn_cnt;
    w_ptr_nxt   = r_ptr;
    w_last_nxt  = r_last;
    w_do_grant  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
`ifdef ULA_BUS_PARK_EN
          // A parked bus may only be handed to a different unit after a turnaround.
          if (r_park_vld && (w_pick_idx != r_last)) begin
            w_state_nxt = S_TURN;
            w_turn_nxt  = 2'd0;
          end else begin
            w_do_grant = 1'b1;
          end
`else
          w_do_grant = 1'b1;
`endif
        end
      end
      S_GRANT: begin
        if (!req[r_last] || ((r_hold_cnt == HOLD_LAST) && w_others)) begin
          w_state_nxt = S_TURN;
          w_gnt_nxt   = 3'b000;
          w_turn_nxt  = 2'd0;
          w_ptr_nxt   = f_inc3(r_last);
        end else if (r_hold_cnt != HOLD_LAST) begin
          w_hold_nxt = r_hold_cnt + 4'd1;
        end
      end
      S_TURN: begin
        if (r_turn_cnt == TURN_LAST) begin
          if (w_pick_vld) begin
            w_do_grant = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_turn_nxt = r_turn_cnt + 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 3'b000;
      end
    endcase

    if (w_do_grant) begin
      w_state_nxt = S_GRANT;
      w_gnt_nxt   = f_onehot(w_pick_idx);
      w_hold_nxt  = 4'd0;
      w_last_nxt  = w_pick_idx;
    end
  end

  always_comb begin
    w_owner_nxt = f_enc(w_gnt_nxt);
`ifdef ULA_BUS_PARK_EN
    w_park_vld_nxt = r_park_vld | w_do_grant;
    w_parked_nxt   = (w_state_nxt == S_IDLE) && w_park_vld_nxt;
    w_en_nxt       = w_parked_nxt ? f_onehot(w_last_nxt) : w_gnt_nxt;
`else
    w_en_nxt = w_gnt_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= 3'b000;
      r_en       <= 3'b000;
      r_owner    <= 2'd3;
      r_ptr      <= 2'd0;
      r_last     <= 2'd0;
      r_hold_cnt <= 4'd0;
      r_turn_cnt <= 2'd0;
`ifdef ULA_BUS_PARK_EN
      r_parked   <= 1'b0;
      r_park_vld <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_en       <= w_en_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_turn_cnt <= w_turn_nxt;
`ifdef ULA_BUS_PARK_EN
      r_parked   <= w_parked_nxt;
      r_park_vld <= w_park_vld_nxt;
`endif
    end
  end

  assign gnt   = r_gnt;
  assign en    = r_en;
  assign owner = r_owner;
`ifdef ULA_BUS_PARK_EN
  assign parked = r_parked;
`else
  assign parked = 1'b0;
`endif

endmodule

// File: doc/ula_bus_arbiter.md
ULA_BUS_ARBITER -- requirements
Module: ula_bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, max consecutive grant cycles while another requester waits (range 2..15).
REQ-002 Parameter TURN_CYCLES, default 1, bus-idle turnaround cycles between grants (range 1..3).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  3  requests: bit0 logic unit, bit1 arithmetic unit (9-bit), bit2 no-carry unit (8-bit); held high while bus wanted.
REQ-006 gnt  output  3  registered grant, one-hot or zero.
REQ-007 en  output  3  tri-state buffer enables, same bit mapping as req, wired to the three buffer EN pins.
REQ-008 owner  output  2  encoded current grantee 0/1/2; 3 = none.
REQ-009 parked  output  1  high when en drives a parked owner with gnt zero (macro-only; constant 0 otherwise).

Function
REQ-010 FSM states IDLE, GRANT, TURN; registered outputs; req-to-gnt latency exactly 1 cycle from IDLE.
REQ-011 IDLE: any req set -> select via round-robin from pointer ptr, next cycle gnt one-hot, state GRANT, hold_cnt=0.
REQ-012 Round-robin: search order ptr, ptr+1, ptr+2 modulo 3 (2 wraps to 0); ptr updates to owner+1 mod 3 on every release.
REQ-013 GRANT: hold_cnt increments each cycle, saturating at MAX_HOLD-1.
REQ-014 GRANT release: req[owner] low -> next cycle gnt=0, state TURN.
REQ-015 GRANT preempt: hold_cnt==MAX_HOLD-1 and another req bit set -> next cycle gnt=0, state TURN.
REQ-016 No other requester pending -> owner keeps grant indefinitely; hold_cnt stays saturated.
REQ-017 Release and preempt in same cycle -> single release, identical outcome.
REQ-018 TURN: gnt=0, en=0 for exactly TURN_CYCLES cycles; then any req -> grant next cycle (arbitrated per ptr), else IDLE.
REQ-019 Previous owner re-requesting during TURN competes normally; ptr already excludes it from first priority.
REQ-020 en equals gnt (without park feature); owner equals encoded gnt.
REQ-021 Invariant: popcount(en) <= 1 every cycle; any change of en from one set bit to another passes through >= TURN_CYCLES all-zero cycles.
REQ-022 req changes while GRANT to a non-owner bit have no effect until release/preempt.

Reset
REQ-023 rst_n low at a rising edge -> next cycle: state IDLE, gnt=0, en=0, owner=3, parked=0, ptr=0, hold_cnt=0.
REQ-024 Reset mid-GRANT or mid-TURN aborts immediately with no turnaround; reset dominates all requests.
REQ-025 First grant after reset release follows REQ-011 with ptr=0.

Configuration
REQ-026 Macro ULA_BUS_PARK_EN defined: after TURN ends with no request, en holds one-hot of last owner, parked=1, bus never floats.
REQ-027 With ULA_BUS_PARK_EN, request from parked owner -> grant next cycle, no turnaround; request from other unit -> en=0 for TURN_CYCLES, then grant.
REQ-028 With ULA_BUS_PARK_EN, no parking before first grant after reset (en=0, bus floats).
REQ-029 ULA_BUS_PARK_EN undefined: en==gnt always, parked tied 0, bus floats ('z') in IDLE/TURN.

Verification
REQ-030 Reset, req=3'b000 -> gnt=0, en=0, owner=3 every cycle.
REQ-031 req=3'b111 held, defaults -> gnt sequence 001 x4, 000 x1, 010 x4, 000 x1, 100 x4, 000 x1, 001 ...
REQ-032 req=3'b010 for 2 cycles then 0 -> gnt 010 at cycles 1-2, 000 thereafter, ptr=2.
REQ-033 req=3'b100 held 10 cycles alone -> gnt 100 all 10 cycles, no preemption.
REQ-034 rst_n low during gnt=010 -> next cycle gnt=0, en=0, owner=3; req=3'b110 after release -> gnt=010.
REQ-035 ULA_BUS_PARK_EN, grant to bit0 then idle -> en=001, parked=1; req=3'b001 -> gnt=001 next cycle; req=3'b100 -> en=000 one cycle, then gnt=100.
